// File: rtl/el2_bp_pkg.sv
// ============================================================================
// Module : el2_bp_pkg
// Brief  : Shared GHR/checkpoint types and the GHR shift helper for the
//          branch-predictor history path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package el2_bp_pkg;

  localparam int EL2_BHT_GHR_SIZE = 8;
  localparam int EL2_CKPT_DEPTH   = 4;
  localparam int EL2_CKPT_AW      = $clog2(EL2_CKPT_DEPTH);

  typedef logic [EL2_BHT_GHR_SIZE-1:0] ghr_t;
  typedef logic [EL2_CKPT_AW-1:0]      ckpt_tag_t;

  // Newest outcome enters at bit 0; the oldest bit falls off the top.
  function automatic ghr_t ghr_shift(input ghr_t g, input logic b);
    return {g[EL2_BHT_GHR_SIZE-2:0], b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/el2_bp_ghr_ckpt_ram.sv
// ============================================================================
// Module : el2_bp_ghr_ckpt_ram
// Brief  : DEPTH x WIDTH flop array holding pre-prediction GHR checkpoints;
//          one synchronous write port, one asynchronous read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module el2_bp_ghr_ckpt_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // Contents are meaningless until written, so the array carries no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/el2_bp_ghr_tracker.sv
// ============================================================================
// Module : el2_bp_ghr_tracker
// Brief  : Speculative/committed global history tracker with a checkpoint
//          ring for mispredict recovery. Optional EL2_BP_GHR_PERF_EN adds a
//          saturating 16-bit mispredict counter on port mp_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module el2_bp_ghr_tracker
  import el2_bp_pkg::*;
#(
  parameter int BHT_GHR_SIZE = EL2_BHT_GHR_SIZE,
  parameter int CKPT_DEPTH   = EL2_CKPT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          pred_valid,
  input  logic                          pred_taken,
  output logic                          pred_ready,
  output logic [$clog2(CKPT_DEPTH)-1:0] pred_tag,
  input  logic                          mp_valid,
  input  logic [$clog2(CKPT_DEPTH)-1:0] mp_tag,
  input  logic                          mp_actual,
  input  logic                          ret_valid,
  input  logic                          ret_taken,
  input  logic                          flush,
`ifdef EL2_BP_GHR_PERF_EN
  output logic [15:0]                   mp_count,
`endif
  output logic [BHT_GHR_SIZE-1:0]       ghr,
  output logic [BHT_GHR_SIZE-1:0]       ghr_arch
);

  localparam int                CKPT_AW  = $clog2(CKPT_DEPTH);
  localparam int                CNT_W    = CKPT_AW + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CKPT_DEPTH);

  ghr_t             ghr_q, ghr_d;
  ghr_t             ghr_arch_q, ghr_arch_d;
  ghr_t             ckpt_rdata;
  ckpt_tag_t        wr_ptr_q, wr_ptr_d;
  ckpt_tag_t        rd_ptr_q, rd_ptr_d;
  ckpt_tag_t        mp_span;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pred_fire;

  assign pred_ready = (count_q < FULL_CNT);
  assign pred_tag   = wr_ptr_q;
  assign ghr        = ghr_q;
  assign ghr_arch   = ghr_arch_q;
  assign pred_fire  = pred_valid & pred_ready & ~mp_valid & ~flush;

  always_comb begin
    ghr_arch_d = ret_valid ? ghr_shift(ghr_arch_q, ret_taken) : ghr_arch_q;
    rd_ptr_d   = rd_ptr_q + ckpt_tag_t'(ret_valid);
    // Survivors after a mispredict run from the post-retire head to mp_tag.
    mp_span    = mp_tag - rd_ptr_d + ckpt_tag_t'(1);
    ghr_d      = ghr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q - CNT_W'(ret_valid);
    if (flush) begin
      ghr_d    = ghr_arch_d;
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else if (mp_valid) begin
      ghr_d    = ghr_shift(ckpt_rdata, mp_actual);
      wr_ptr_d = mp_tag + ckpt_tag_t'(1);
      // A zero span can only mean the whole ring survives.
      count_d  = (mp_span == '0) ? FULL_CNT : {1'b0, mp_span};
    end else if (pred_fire) begin
      ghr_d    = ghr_shift(ghr_q, pred_taken);
      wr_ptr_d = wr_ptr_q + ckpt_tag_t'(1);
      count_d  = count_q + CNT_W'(1) - CNT_W'(ret_valid);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ghr_q      <= '0;
      ghr_arch_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      ghr_q      <= ghr_d;
      ghr_arch_q <= ghr_arch_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  el2_bp_ghr_ckpt_ram #(
    .DEPTH (CKPT_DEPTH),
    .WIDTH (BHT_GHR_SIZE)
  ) u_ckpt_ram (
    .clk     (clk),
    .we_i    (pred_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (ghr_q),
    .raddr_i (mp_tag),
    .rdata_o (ckpt_rdata)
  );

`ifdef EL2_BP_GHR_PERF_EN
  logic [15:0] mp_count_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mp_count_q <= '0;
    end else if (mp_valid && (mp_count_q != 16'hFFFF)) begin
      mp_count_q <= mp_count_q + 16'd1;
    end
  end

  assign mp_count = mp_count_q;
`endif

`ifndef SYNTHESIS
  ckpt_tag_t mp_age;
  assign mp_age = mp_tag - rd_ptr_q;

  a_ret_nonempty : assert property (@(posedge clk) disable iff (!rst_l)
    ret_valid |-> (count_q != '0));
  a_mp_inflight : assert property (@(posedge clk) disable iff (!rst_l)
    mp_valid |-> ({1'b0, mp_age} < count_q));
  a_ret_mp_head : assert property (@(posedge clk) disable iff (!rst_l)
    (ret_valid && mp_valid) |-> (mp_tag != rd_ptr_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_el2_bp_ghr_tracker.sv
// ============================================================================
// Module : tb_el2_bp_ghr_tracker
// Brief  : Self-checking bench for el2_bp_ghr_tracker: vector table, directed
//          corner sequences and random traffic against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_el2_bp_ghr_tracker;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       pred_valid, pred_taken, pred_ready;
  logic [1:0] pred_tag, mp_tag;
  logic       mp_valid, mp_actual, ret_valid, ret_taken, flush;
  logic [7:0] ghr, ghr_arch;
`ifdef EL2_BP_GHR_PERF_EN
  logic [15:0] mp_count;
`endif

  el2_bp_ghr_tracker dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_ready (pred_ready),
    .pred_tag   (pred_tag),
    .mp_valid   (mp_valid),
    .mp_tag     (mp_tag),
    .mp_actual  (mp_actual),
    .ret_valid  (ret_valid),
    .ret_taken  (ret_taken),
    .flush      (flush),
`ifdef EL2_BP_GHR_PERF_EN
    .mp_count   (mp_count),
`endif
    .ghr        (ghr),
    .ghr_arch   (ghr_arch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] ctl;   // {pred_valid, pred_taken, ret_valid, ret_taken, flush}
    logic [7:0] eg;
    logic [7:0] ea;
    logic       er;
    logic [1:0] et;
  } vec_t;

  typedef struct {
    logic [1:0] tag;
    logic [7:0] ck;
  } ent_t;

  vec_t       vt[14];
  ent_t       mq[$];
  logic [7:0] m_ghr, m_arch;
  logic [1:0] m_wr, m_rd;
  int         m_mpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic pt, input logic mp, input logic [1:0] mt,
                       input logic ma, input logic rv, input logic rt, input logic fl);
    pred_valid = pv; pred_taken = pt;
    mp_valid = mp; mp_tag = mt; mp_actual = ma;
    ret_valid = rv; ret_taken = rt; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic step(input logic pv, input logic pt, input logic mp, input logic [1:0] mt,
                      input logic ma, input logic rv, input logic rt, input logic fl);
    drive(pv, pt, mp, mt, ma, rv, rt, fl);
    tick();
  endtask

  function automatic logic [7:0] shl(input logic [7:0] g, input logic b);
    return {g[6:0], b};
  endfunction

  // Reference: the in-flight branches as an ordered queue of (tag, saved GHR).
  task automatic model_step();
    int sz0;
    int k;
    sz0 = mq.size();
    if (ret_valid) begin
      void'(mq.pop_front());
      m_arch = shl(m_arch, ret_taken);
      m_rd   = m_rd + 2'd1;
    end
    if (flush) begin
      m_ghr = m_arch;
      mq.delete();
      m_wr  = m_rd;
    end else if (mp_valid) begin
      k = 0;
      foreach (mq[i]) if (mq[i].tag == mp_tag) k = i;
      m_ghr = shl(mq[k].ck, mp_actual);
      while (mq.size() > k + 1) void'(mq.pop_back());
      m_wr = mp_tag + 2'd1;
    end else if (pred_valid && sz0 < 4) begin
      mq.push_back('{m_wr, m_ghr});
      m_ghr = shl(m_ghr, pred_taken);
      m_wr  = m_wr + 2'd1;
    end
    if (mp_valid && m_mpc < 65535) m_mpc++;
  endtask

  initial begin
    int sz, lo, k, r;

    vt[0]  = '{5'b11000, 8'h01, 8'h00, 1'b1, 2'd1};
    vt[1]  = '{5'b10000, 8'h02, 8'h00, 1'b1, 2'd2};
    vt[2]  = '{5'b11000, 8'h05, 8'h00, 1'b1, 2'd3};
    vt[3]  = '{5'b00001, 8'h00, 8'h00, 1'b1, 2'd0};
    vt[4]  = '{5'b11000, 8'h01, 8'h00, 1'b1, 2'd1};
    vt[5]  = '{5'b11000, 8'h03, 8'h00, 1'b1, 2'd2};
    vt[6]  = '{5'b11000, 8'h07, 8'h00, 1'b1, 2'd3};
    vt[7]  = '{5'b11000, 8'h0F, 8'h00, 1'b0, 2'd0};
    vt[8]  = '{5'b11000, 8'h0F, 8'h00, 1'b0, 2'd0};
    vt[9]  = '{5'b00110, 8'h0F, 8'h01, 1'b1, 2'd0};
    vt[10] = '{5'b11001, 8'h01, 8'h01, 1'b1, 2'd1};
    vt[11] = '{5'b10000, 8'h02, 8'h01, 1'b1, 2'd2};
    vt[12] = '{5'b11110, 8'h05, 8'h03, 1'b1, 2'd3};
    vt[13] = '{5'b00100, 8'h05, 8'h06, 1'b1, 2'd3};

    idle();
    rst_l = 1'b0;
    #1;
    check("rst_ghr", 32'(ghr), 32'h00);
    check("rst_arch", 32'(ghr_arch), 32'h00);
    check("rst_ready", 32'(pred_ready), 32'h1);
    check("rst_tag", 32'(pred_tag), 32'h0);
    #11;
    rst_l = 1'b1;

    for (int i = 0; i < 14; i++) begin
      {pred_valid, pred_taken, ret_valid, ret_taken, flush} = vt[i].ctl;
      mp_valid = 1'b0; mp_tag = 2'd0; mp_actual = 1'b0;
      tick();
      check("vec_ghr", 32'(ghr), 32'(vt[i].eg));
      check("vec_arch", 32'(ghr_arch), 32'(vt[i].ea));
      check("vec_ready", 32'(pred_ready), 32'(vt[i].er));
      check("vec_tag", 32'(pred_tag), 32'(vt[i].et));
    end

    // Mispredict recovery, including the newest slot of a full ring.
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mp_pre_ghr", 32'(ghr), 32'h07);
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mp_ghr", 32'(ghr), 32'h02);
    check("mp_tag_next", 32'(pred_tag), 32'h2);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mp_cnt3_ready", 32'(pred_ready), 32'h1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mp_cnt4_ready", 32'(pred_ready), 32'h0);
    check("mp_cnt4_ghr", 32'(ghr), 32'h0B);
    step(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mp_full_ghr", 32'(ghr), 32'h0B);
    check("mp_full_ready", 32'(pred_ready), 32'h0);
    check("mp_full_tag", 32'(pred_tag), 32'h0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mp_ret_ghr", 32'(ghr), 32'h03);
    check("mp_ret_arch", 32'(ghr_arch), 32'h01);
    check("mp_ret_tag", 32'(pred_tag), 32'h2);
    check("mp_ret_ready", 32'(pred_ready), 32'h1);

    // Flush with a same-cycle retire restores from the updated committed GHR.
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("fl_pre_arch", 32'(ghr_arch), 32'h03);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("fl_ghr", 32'(ghr), 32'h07);
    check("fl_arch", 32'(ghr_arch), 32'h07);
    check("fl_tag", 32'(pred_tag), 32'h3);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_cnt3_ready", 32'(pred_ready), 32'h1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl_cnt4_ready", 32'(pred_ready), 32'h0);
    check("fl_cnt4_ghr", 32'(ghr), 32'h70);

    // Reset asserted between edges clears state immediately.
    idle();
    #2;
    rst_l = 1'b0;
    #1;
    check("arst_ghr", 32'(ghr), 32'h00);
    check("arst_arch", 32'(ghr_arch), 32'h00);
    check("arst_ready", 32'(pred_ready), 32'h1);
    check("arst_tag", 32'(pred_tag), 32'h0);
    @(negedge clk);
    rst_l = 1'b1;

    // Pointer wrap over ten predict/retire pairs.
    for (int i = 0; i < 10; i++) begin
      check("wrap_tag", 32'(pred_tag), 32'(i % 4));
      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("wrap_ghr", 32'(ghr), 32'h00);
    check("wrap_arch", 32'(ghr_arch), 32'h00);

`ifdef EL2_BP_GHR_PERF_EN
    do_reset();
    check("perf_rst", 32'(mp_count), 32'h0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("perf_five", 32'(mp_count), 32'h5);
    @(negedge clk);
    force dut.mp_count_q = 16'hFFFF;
    #1;
    release dut.mp_count_q;
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("perf_sat", 32'(mp_count), 32'hFFFF);
`endif

    // Random legal traffic against the queue model.
    do_reset();
    mq.delete();
    m_ghr = '0; m_arch = '0; m_wr = '0; m_rd = '0; m_mpc = 0;
    for (int n = 0; n < 1500; n++) begin
      sz = mq.size();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 2'd0,
            1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      r = int'($urandom_range(0, 99));
      if (r < 3) flush = 1'b1;
      else if (r < 20 && sz > 0) mp_valid = 1'b1;
      if (sz > 0 && $urandom_range(0, 2) == 0) ret_valid = 1'b1;
      if (mp_valid) begin
        lo = ret_valid ? 1 : 0;
        if (sz - 1 < lo) begin
          mp_valid = 1'b0;
        end else begin
          k = int'($urandom_range(lo, sz - 1));
          mp_tag = mq[k].tag;
        end
      end
      model_step();
      tick();
      check("rnd_ghr", 32'(ghr), 32'(m_ghr));
      check("rnd_arch", 32'(ghr_arch), 32'(m_arch));
      check("rnd_ready", 32'(pred_ready), 32'(mq.size() < 4));
      check("rnd_tag", 32'(pred_tag), 32'(m_wr));
`ifdef EL2_BP_GHR_PERF_EN
      check("rnd_mpc", 32'(mp_count), 32'(m_mpc));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
